// File: rtl/cr_huf_comp_ht_sort_rx_pkg.sv
// Shared types for the insertion-sorter to Huffman-tree receive path.
// Also holds the pipe eob encoding reused across cr_huf_comp.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

package cr_huf_compPKG;

  localparam int HT_DAT_W   = 10;
  localparam int HT_FREQ_W  = 15;
  localparam int HT_SEQID_W = `CREOLE_HC_SEQID_WIDTH;

  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    END       = 2'd1,
    PASS_THRU = 2'd2,
    TRACE     = 2'd3
  } e_pipe_eob;

  typedef enum logic [1:0] {
    HT_RX_IDLE   = 2'd0,
    HT_RX_STREAM = 2'd1,
    HT_RX_NULL   = 2'd2
  } e_ht_rx_state;

  typedef struct packed {
    logic [HT_DAT_W-1:0]  sym;
    logic [HT_FREQ_W-1:0] freq;
  } sym_entry_t;

  typedef struct packed {
    logic [HT_DAT_W-1:0]  sym;
    logic [HT_FREQ_W-1:0] freq;
    logic                 first;
    logic                 last;
    e_pipe_eob            eob;
    logic                 err;
  } st_beat_t;

  localparam st_beat_t ST_BEAT_IDLE = '{
    sym:   '0,
    freq:  '0,
    first: 1'b0,
    last:  1'b0,
    eob:   MIDDLE,
    err:   1'b0
  };

  // eob and err only ride on the last beat of a frame
  function automatic st_beat_t ht_mk_beat(
    input logic [HT_DAT_W-1:0]  sym,
    input logic [HT_FREQ_W-1:0] freq,
    input logic                 first,
    input logic                 last,
    input e_pipe_eob            eob,
    input logic                 err
  );
    st_beat_t b;
    b.sym   = sym;
    b.freq  = freq;
    b.first = first;
    b.last  = last;
    b.eob   = last ? eob : MIDDLE;
    b.err   = last & err;
    return b;
  endfunction

endpackage

// File: rtl/cr_huf_comp_ht_sort_rx_chk.sv
// Per-beat sort-order and zero-frequency checker.
// err_nxt includes the beat being loaded this cycle.
module cr_huf_comp_ht_sort_rx_chk #(
  parameter int SYM_FREQ_WIDTH = 15
) (
  input  logic                      clk_gated,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      step,
  input  logic [SYM_FREQ_WIDTH-1:0] freq,
  output logic                      err_nxt
);

  logic [SYM_FREQ_WIDTH-1:0] prev_q, prev_d;
  logic                      err_q, err_d;

  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    unique case (1'b1)
      start: begin
        prev_d = freq;
        err_d  = (freq == '0);
      end
      step: begin
        prev_d = freq;
        err_d  = err_q | (freq == '0) | (freq < prev_q);
      end
      default: ;
    endcase
  end

  assign err_nxt = err_d;

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/cr_huf_comp_ht_sort_rx.sv
// Captures a sorted frequency table and streams its non-zero
// entries to the Huffman tree builder, one per cycle.
module cr_huf_comp_ht_sort_rx
  import cr_huf_compPKG::*;
#(
  parameter int DAT_WIDTH        = 10,
  parameter int SYM_FREQ_WIDTH   = 15,
  parameter int CNTRL_WIDTH      = 1,
  parameter int MAX_NUM_SYM_USED = 576
) (
  input  logic                              clk_gated,
  input  logic                              rst_n,
  input  logic [DAT_WIDTH-1:0]              is_ht_sym_lo,
  input  logic [DAT_WIDTH-1:0]              is_ht_sym_hi,
  input  logic [DAT_WIDTH-1:0]              is_ht_sym_unique,
  input  logic [SYM_FREQ_WIDTH-1:0]         is_ht_sym_sort_freq [MAX_NUM_SYM_USED],
  input  logic [DAT_WIDTH-1:0]              is_ht_sym_sort_freq_sym [MAX_NUM_SYM_USED],
  input  logic [CNTRL_WIDTH-1:0]            is_ht_meta,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0] is_ht_seq_id,
  input  e_pipe_eob                         is_ht_eob,
  output logic                              ht_is_not_ready,
  input  logic                              st_rdy,
  output logic                              st_vld,
  output logic [DAT_WIDTH-1:0]              st_sym,
  output logic [SYM_FREQ_WIDTH-1:0]         st_freq,
  output logic                              st_first,
  output logic                              st_last,
  output logic [DAT_WIDTH:0]                st_num_sym,
  output logic [CNTRL_WIDTH-1:0]            st_meta,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0] st_seq_id,
  output e_pipe_eob                         st_eob,
  output logic                              st_err
);

  localparam int MAX = MAX_NUM_SYM_USED;
  localparam logic [DAT_WIDTH:0]   MAX_W    = (DAT_WIDTH+1)'(MAX);
  localparam logic [DAT_WIDTH-1:0] LAST_IDX = DAT_WIDTH'(MAX - 1);

  e_ht_rx_state                  state_q, state_d;
  logic [DAT_WIDTH-1:0]          ptr_q, ptr_d;
  logic                          vld_q, vld_d;
  st_beat_t                      beat_q, beat_d;
  logic [DAT_WIDTH:0]            num_q, num_d;
  logic [CNTRL_WIDTH-1:0]        meta_q, meta_d;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0] seq_q, seq_d;
  e_pipe_eob                     eob_q, eob_d;
  logic [DAT_WIDTH-1:0]          lo_q, lo_d;
  logic [DAT_WIDTH-1:0]          hi_q, hi_d;
  sym_entry_t                    tbl_q [MAX];
  sym_entry_t                    tbl_d [MAX];

  logic                          cap;
  logic                          acc;
  logic [DAT_WIDTH:0]            uniq_w;
  logic                          uniq_ok;
  logic                          uniq_ovf;
  logic [DAT_WIDTH-1:0]          uidx;
  logic [DAT_WIDTH-1:0]          nxt_idx;
  logic                          chk_start;
  logic                          chk_step;
  logic [SYM_FREQ_WIDTH-1:0]     chk_freq;
  logic                          chk_err;

  assign cap      = (state_q == HT_RX_IDLE) & (is_ht_eob != MIDDLE);
  assign acc      = vld_q & st_rdy;
  assign uniq_w   = {1'b0, is_ht_sym_unique};
  assign uniq_ok  = uniq_w < MAX_W;
  assign uniq_ovf = uniq_w > MAX_W;
  assign uidx     = uniq_ok ? is_ht_sym_unique : '0;
  assign nxt_idx  = ptr_q + 1'b1;

  assign ht_is_not_ready = (state_q != HT_RX_IDLE) | (is_ht_eob != MIDDLE);

  cr_huf_comp_ht_sort_rx_chk #(
    .SYM_FREQ_WIDTH (SYM_FREQ_WIDTH)
  ) u_chk (
    .clk_gated (clk_gated),
    .rst_n     (rst_n),
    .start     (chk_start),
    .step      (chk_step),
    .freq      (chk_freq),
    .err_nxt   (chk_err)
  );

  // The first beat is loaded straight from the inputs so it is
  // visible the cycle after capture.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    vld_d     = vld_q;
    beat_d    = beat_q;
    num_d     = num_q;
    meta_d    = meta_q;
    seq_d     = seq_q;
    eob_d     = eob_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    tbl_d     = tbl_q;
    chk_start = 1'b0;
    chk_step  = 1'b0;
    chk_freq  = '0;
    unique case (state_q)
      HT_RX_IDLE: begin
        if (cap) begin
          for (int i = 0; i < MAX; i++) begin
            tbl_d[i].sym  = is_ht_sym_sort_freq_sym[i];
            tbl_d[i].freq = is_ht_sym_sort_freq[i];
          end
          lo_d      = is_ht_sym_lo;
          hi_d      = is_ht_sym_hi;
          meta_d    = is_ht_meta;
          seq_d     = is_ht_seq_id;
          eob_d     = is_ht_eob;
          num_d     = uniq_ovf ? '0 : MAX_W - uniq_w;
          ptr_d     = is_ht_sym_unique;
          vld_d     = 1'b1;
          chk_start = 1'b1;
          chk_freq  = is_ht_sym_sort_freq[uidx];
          if (is_ht_eob == PASS_THRU || !uniq_ok) begin
            state_d = HT_RX_NULL;
            beat_d  = ht_mk_beat('0, '0, 1'b1, 1'b1,
                                 is_ht_eob, uniq_ovf);
          end else begin
            state_d = HT_RX_STREAM;
            beat_d  = ht_mk_beat(
              is_ht_sym_sort_freq_sym[uidx],
              is_ht_sym_sort_freq[uidx],
              1'b1,
              is_ht_sym_unique == LAST_IDX,
              is_ht_eob,
              chk_err);
          end
        end
      end
      HT_RX_STREAM: begin
        if (acc) begin
          if (beat_q.last) begin
            state_d = HT_RX_IDLE;
            vld_d   = 1'b0;
            beat_d  = ST_BEAT_IDLE;
          end else begin
            ptr_d    = nxt_idx;
            chk_step = 1'b1;
            chk_freq = tbl_q[nxt_idx].freq;
            beat_d   = ht_mk_beat(
              tbl_q[nxt_idx].sym,
              tbl_q[nxt_idx].freq,
              1'b0,
              nxt_idx == LAST_IDX,
              eob_q,
              chk_err);
          end
        end
      end
      HT_RX_NULL: begin
        if (acc) begin
          state_d = HT_RX_IDLE;
          vld_d   = 1'b0;
          beat_d  = ST_BEAT_IDLE;
        end
      end
      default: begin
        state_d = HT_RX_IDLE;
        vld_d   = 1'b0;
        beat_d  = ST_BEAT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HT_RX_IDLE;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      beat_q  <= ST_BEAT_IDLE;
      num_q   <= '0;
      meta_q  <= '0;
      seq_q   <= '0;
      eob_q   <= MIDDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      for (int i = 0; i < MAX; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      beat_q  <= beat_d;
      num_q   <= num_d;
      meta_q  <= meta_d;
      seq_q   <= seq_d;
      eob_q   <= eob_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      tbl_q   <= tbl_d;
    end
  end

  assign st_vld     = vld_q;
  assign st_sym     = beat_q.sym;
  assign st_freq    = beat_q.freq;
  assign st_first   = beat_q.first;
  assign st_last    = beat_q.last;
  assign st_eob     = beat_q.eob;
  assign st_err     = beat_q.err;
  assign st_num_sym = num_q;
  assign st_meta    = meta_q;
  assign st_seq_id  = seq_q;

endmodule

// File: tb/tb_cr_huf_comp_ht_sort_rx.sv
// Directed bench for cr_huf_comp_ht_sort_rx.
// Inputs driven and outputs sampled on the falling edge.
module tb_cr_huf_comp_ht_sort_rx;
  import cr_huf_compPKG::*;

  localparam int DW = 10;
  localparam int FW = 15;
  localparam int M  = 576;
  localparam int SW = `CREOLE_HC_SEQID_WIDTH;

  logic          clk_gated = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] lo = '0, hi = '0, uniq = '0;
  logic [FW-1:0] freq_a [M];
  logic [DW-1:0] sym_a  [M];
  logic [0:0]    meta = '0;
  logic [SW-1:0] seq = '0;
  e_pipe_eob     eob = MIDDLE;
  logic          nr;
  logic          st_rdy = 1'b1;
  logic          st_vld, st_first, st_last, st_err;
  logic [DW-1:0] st_sym;
  logic [FW-1:0] st_freq;
  logic [DW:0]   st_num_sym;
  logic [0:0]    st_meta;
  logic [SW-1:0] st_seq_id;
  e_pipe_eob     st_eob;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk_gated = ~clk_gated;

  cr_huf_comp_ht_sort_rx dut (
    .clk_gated               (clk_gated),
    .rst_n                   (rst_n),
    .is_ht_sym_lo            (lo),
    .is_ht_sym_hi            (hi),
    .is_ht_sym_unique        (uniq),
    .is_ht_sym_sort_freq     (freq_a),
    .is_ht_sym_sort_freq_sym (sym_a),
    .is_ht_meta              (meta),
    .is_ht_seq_id            (seq),
    .is_ht_eob               (eob),
    .ht_is_not_ready         (nr),
    .st_rdy                  (st_rdy),
    .st_vld                  (st_vld),
    .st_sym                  (st_sym),
    .st_freq                 (st_freq),
    .st_first                (st_first),
    .st_last                 (st_last),
    .st_num_sym              (st_num_sym),
    .st_meta                 (st_meta),
    .st_seq_id               (st_seq_id),
    .st_eob                  (st_eob),
    .st_err                  (st_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bt(
    input logic v, input logic [DW-1:0] s, input logic [FW-1:0] f,
    input logic fi, input logic la, input e_pipe_eob e, input logic er);
    return {1'b0, v, s, f, fi, la, e, er};
  endfunction

  function automatic logic [31:0] obs_bt();
    return {1'b0, st_vld, st_sym, st_freq, st_first, st_last,
            st_eob, st_err};
  endfunction

  task automatic cyc();
    @(negedge clk_gated);
  endtask

  task automatic clr_tbl();
    for (int i = 0; i < M; i++) begin
      freq_a[i] = '0;
      sym_a[i]  = DW'(i);
    end
  endtask

  task automatic put(input int idx, input int s, input int f);
    sym_a[idx]  = DW'(s);
    freq_a[idx] = FW'(f);
  endtask

  // Table is offered for one cycle only; the DUT must be idle.
  task automatic present(input string tag, input e_pipe_eob e,
                         input int u, input logic m,
                         input logic [SW-1:0] s);
    chk({tag, "_proto_idle"}, 32'(nr), 32'd0);
    uniq = DW'(u);
    meta = m;
    seq  = s;
    lo   = '0;
    hi   = DW'(M - 1);
    eob  = e;
    #1;
    chk({tag, "_nr_cap"}, 32'(nr), 32'd1);
    cyc();
    eob = MIDDLE;
  endtask

  initial begin
    clr_tbl();
    cyc();
    cyc();
    chk("rst_beat", obs_bt(), bt(0, 0, 0, 0, 0, MIDDLE, 0));
    chk("rst_num", 32'(st_num_sym), 32'd0);
    chk("rst_meta_seq", {st_meta, st_seq_id}, 32'd0);
    chk("rst_nr", 32'(nr), 32'd0);
    rst_n = 1'b1;
    cyc();

    // three symbols, free-running sink
    put(573, 7, 2);
    put(574, 3, 5);
    put(575, 100, 9);
    present("t1", END, 573, 1'b1, SW'(5));
    chk("t1_b0", obs_bt(), bt(1, 7, 2, 1, 0, MIDDLE, 0));
    chk("t1_num", 32'(st_num_sym), 32'd3);
    chk("t1_meta_seq", {st_meta, st_seq_id}, {1'b1, SW'(5)});
    chk("t1_nr1", 32'(nr), 32'd1);
    cyc();
    chk("t1_b1", obs_bt(), bt(1, 3, 5, 0, 0, MIDDLE, 0));
    chk("t1_nr2", 32'(nr), 32'd1);
    cyc();
    chk("t1_b2", obs_bt(), bt(1, 100, 9, 0, 1, END, 0));
    chk("t1_nr3", 32'(nr), 32'd1);
    cyc();
    chk("t1_done", 32'(st_vld), 32'd0);
    chk("t1_nr4", 32'(nr), 32'd0);

    // same table, sink stalls on the second beat
    present("t2", END, 573, 1'b0, SW'(6));
    chk("t2_b0", obs_bt(), bt(1, 7, 2, 1, 0, MIDDLE, 0));
    cyc();
    st_rdy = 1'b0;
    chk("t2_b1", obs_bt(), bt(1, 3, 5, 0, 0, MIDDLE, 0));
    cyc();
    chk("t2_hold1", obs_bt(), bt(1, 3, 5, 0, 0, MIDDLE, 0));
    cyc();
    st_rdy = 1'b1;
    chk("t2_hold2", obs_bt(), bt(1, 3, 5, 0, 0, MIDDLE, 0));
    cyc();
    chk("t2_b2", obs_bt(), bt(1, 100, 9, 0, 1, END, 0));
    cyc();
    chk("t2_done", 32'(st_vld), 32'd0);

    // pass-through frame
    present("t3", PASS_THRU, 573, 1'b0, SW'(7));
    chk("t3_null", obs_bt(), bt(1, 0, 0, 1, 1, PASS_THRU, 0));
    cyc();
    chk("t3_done", 32'(st_vld), 32'd0);
    chk("t3_idle", 32'(nr), 32'd0);

    // unique at the table depth: empty frame, no error
    present("t4", END, 576, 1'b0, SW'(8));
    chk("t4_null", obs_bt(), bt(1, 0, 0, 1, 1, END, 0));
    chk("t4_num", 32'(st_num_sym), 32'd0);
    cyc();

    // unique past the table depth
    present("t4b", END, 600, 1'b0, SW'(9));
    chk("t4b_null", obs_bt(), bt(1, 0, 0, 1, 1, END, 1));
    chk("t4b_num", 32'(st_num_sym), 32'd0);
    cyc();

    // descending pair
    put(574, 1, 4);
    put(575, 2, 3);
    present("t5", END, 574, 1'b0, SW'(10));
    chk("t5_b0", obs_bt(), bt(1, 1, 4, 1, 0, MIDDLE, 0));
    chk("t5_num", 32'(st_num_sym), 32'd2);
    cyc();
    chk("t5_b1", obs_bt(), bt(1, 2, 3, 0, 1, END, 1));
    cyc();

    // zero frequency inside the non-zero range
    put(573, 7, 2);
    put(574, 3, 0);
    put(575, 100, 9);
    present("t6", END, 573, 1'b0, SW'(11));
    chk("t6_b0", obs_bt(), bt(1, 7, 2, 1, 0, MIDDLE, 0));
    cyc();
    chk("t6_b1", obs_bt(), bt(1, 3, 0, 0, 0, MIDDLE, 0));
    cyc();
    chk("t6_b2", obs_bt(), bt(1, 100, 9, 0, 1, END, 1));
    cyc();

    // reset in the middle of a 10-symbol frame
    for (int k = 0; k < 10; k++) put(566 + k, 20 + k, k + 1);
    present("t7", END, 566, 1'b1, SW'(12));
    chk("t7_b0", obs_bt(), bt(1, 20, 1, 1, 0, MIDDLE, 0));
    chk("t7_num", 32'(st_num_sym), 32'd10);
    cyc();
    chk("t7_b1", obs_bt(), bt(1, 21, 2, 0, 0, MIDDLE, 0));
    rst_n = 1'b0;
    #1;
    chk("t7_rst_beat", obs_bt(), bt(0, 0, 0, 0, 0, MIDDLE, 0));
    chk("t7_rst_num", 32'(st_num_sym), 32'd0);
    chk("t7_rst_nr", 32'(nr), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    put(573, 7, 2);
    put(574, 3, 5);
    put(575, 100, 9);
    present("t8", END, 573, 1'b0, SW'(13));
    chk("t8_b0", obs_bt(), bt(1, 7, 2, 1, 0, MIDDLE, 0));
    chk("t8_num", 32'(st_num_sym), 32'd3);
    cyc();
    chk("t8_b1", obs_bt(), bt(1, 3, 5, 0, 0, MIDDLE, 0));
    cyc();
    chk("t8_b2", obs_bt(), bt(1, 100, 9, 0, 1, END, 0));
    cyc();
    chk("t8_done", 32'(st_vld), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
